// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a shared-memory multicycle RV32I core.
// Sequences mux selects, ALU op and strobes; counts retirements; traps.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             adr_src_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       imm_src_o,
  output logic [2:0]       alu_control_o,
  output logic             reg_write_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [3:0]       state_dbg_o,
  output logic [CNT_W-1:0] instr_retired_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] C_OPC = 2'b01;
  localparam logic [1:0] C_FN  = 2'b10;
  localparam logic [1:0] C_TO  = 2'b11;

  localparam int WW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX =
    (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             waiting;
  logic             timed_out;
  logic             f3_ok;
  logic             sub_ok;
  logic [2:0]       alu_dec;

  assign f3_ok = (funct3_i == 3'b000)
               | (funct3_i == 3'b010)
               | (funct3_i == 3'b110)
               | (funct3_i == 3'b111);

  assign waiting = (state_q == S_FETCH)
                 | (state_q == S_MEMREAD)
                 | (state_q == S_MEMWRITE);

  assign timed_out = (TIMEOUT != 0)
                   & (wait_q == WAIT_MAX)
                   & ~mem_ready_i;

  // next state, trap cause and retirement
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = C_TO;
        end
      end
      S_DECODE: begin
        unique case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            state_d = f3_ok ? S_EXECR : S_TRAP;
            if (!f3_ok) cause_d = C_FN;
          end
          OP_I: begin
            state_d = f3_ok ? S_EXECI : S_TRAP;
            if (!f3_ok) cause_d = C_FN;
          end
          OP_BEQ: begin
            if (funct3_i == 3'b000) begin
              state_d = S_BEQ;
            end else begin
              state_d = S_TRAP;
              cause_d = C_FN;
            end
          end
          OP_JAL: state_d = S_JAL;
          default: begin
            state_d = S_TRAP;
            cause_d = C_OPC;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready_i) begin
          state_d = S_MEMWB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = C_TO;
        end
      end
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = C_TO;
        end
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL: state_d = S_ALUWB;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // wait counter restarts whenever the state changes
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && !mem_ready_i) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // all architectural control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= (state_d == S_TRAP);
      cause_q <= cause_d;
      cnt_q   <= cnt_q
               + {{(CNT_W-1){1'b0}}, retire};
    end
  end

  assign sub_ok = funct7b5_i
                & (state_q == S_EXECR);

  // ALU op from funct3; sub only for R-type
  always_comb begin
    alu_dec = ALU_ADD;
    unique case (1'b1)
      (funct3_i == 3'b000):
        alu_dec = sub_ok ? ALU_SUB : ALU_ADD;
      (funct3_i == 3'b010): alu_dec = ALU_SLT;
      (funct3_i == 3'b110): alu_dec = ALU_OR;
      (funct3_i == 3'b111): alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // datapath controls, forced low while in reset
  always_comb begin
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    imm_src_o     = 2'b00;
    alu_control_o = ALU_ADD;
    if (rst_ni) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read_o   = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          ir_write_o   = mem_ready_i;
          pc_write_o   = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b01;
          imm_src_o   =
            (op_i == OP_JAL) ? 2'b11 : 2'b10;
        end
        S_MEMADR: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
          imm_src_o   = op_i[5] ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          adr_src_o  = 1'b1;
          mem_read_o = 1'b1;
        end
        S_MEMWB: begin
          result_src_o = 2'b01;
          reg_write_o  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src_o   = 1'b1;
          mem_write_o = 1'b1;
        end
        S_EXECR: begin
          alu_src_a_o   = 2'b10;
          alu_control_o = alu_dec;
        end
        S_EXECI: begin
          alu_src_a_o   = 2'b10;
          alu_src_b_o   = 2'b01;
          alu_control_o = alu_dec;
        end
        S_ALUWB: reg_write_o = 1'b1;
        S_BEQ: begin
          alu_src_a_o   = 2'b10;
          alu_control_o = ALU_SUB;
          pc_write_o    = zero_i;
        end
        S_JAL: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          pc_write_o  = 1'b1;
        end
        default: pc_write_o = 1'b0;
      endcase
    end
  end

  assign trap_o          = trap_q;
  assign trap_cause_o    = cause_q;
  assign state_dbg_o     = state_q;
  assign instr_retired_o = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + random checks of the control FSM
// against a per-instruction cycle-plan model.
module tb_multicycle_control;

  localparam int TO = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic b5 = 1'b0;
  logic zero = 1'b0;
  logic ready = 1'b0;

  logic pc_write, adr_src, mem_read, mem_write;
  logic ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [1:0] imm_src, trap_cause;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;
  logic [CW-1:0] instr_retired;
  logic [16:0] act_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic exp_trap = 1'b0;
  logic [1:0] exp_cause = 2'b00;

  typedef struct {
    int   st;
    logic rdy;
  } step_t;
  step_t plan[$];

  multicycle_control #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .op_i(op), .funct3_i(f3),
    .funct7b5_i(b5), .zero_i(zero),
    .mem_ready_i(ready),
    .pc_write_o(pc_write), .adr_src_o(adr_src),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .ir_write_o(ir_write),
    .result_src_o(result_src),
    .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b),
    .imm_src_o(imm_src),
    .alu_control_o(alu_control),
    .reg_write_o(reg_write),
    .trap_o(trap), .trap_cause_o(trap_cause),
    .state_dbg_o(state_dbg),
    .instr_retired_o(instr_retired)
  );

  assign act_ctrl = {pc_write, adr_src, mem_read,
                     mem_write, ir_write, reg_write,
                     result_src, alu_src_a, alu_src_b,
                     imm_src, alu_control};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(
      input logic [2:0] f, input logic use_sub);
    case (f)
      3'b000:  return use_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // control table read straight from the state descriptions
  function automatic logic [16:0] exp_ctrl(
      input int st, input logic r);
    logic pw, as, mr, mw, iw, rw;
    logic [1:0] rs, sa, sb, is;
    logic [2:0] ac;
    {pw, as, mr, mw, iw, rw} = '0;
    {rs, sa, sb, is} = '0;
    ac = 3'b000;
    case (st)
      0: begin
        mr = 1; sb = 2; rs = 2; iw = r; pw = r;
      end
      1: begin
        sa = 1; sb = 1;
        is = (op == 7'b1101111) ? 2'd3 : 2'd2;
      end
      2: begin
        sa = 2; sb = 1;
        is = (op == 7'b0100011) ? 2'd1 : 2'd0;
      end
      3: begin as = 1; mr = 1; end
      4: begin rs = 1; rw = 1; end
      5: begin as = 1; mw = 1; end
      6: begin sa = 2; sb = 0; ac = alu_of(f3, b5); end
      7: rw = 1;
      8: begin sa = 2; sb = 1; ac = alu_of(f3, 1'b0); end
      9: begin sa = 1; sb = 2; pw = 1; end
      10: begin sa = 2; ac = 3'b001; pw = zero; end
      default: ;
    endcase
    return {pw, as, mr, mw, iw, rw,
            rs, sa, sb, is, ac};
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    case (cls)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic add(input int st, input logic r);
    step_t s;
    s.st = st;
    s.rdy = r;
    plan.push_back(s);
  endtask

  // one cycle: drive at negedge, check just after
  task automatic cyc(input int st, input logic r);
    logic [CW-1:0] ec;
    ec = CW'(exp_cnt);
    ready = r;
    #1;
    chk("state", 32'(state_dbg), st);
    chk("ctrl", 32'(act_ctrl), 32'(exp_ctrl(st, r)));
    chk("trap", 32'({trap, trap_cause}),
        32'({exp_trap, exp_cause}));
    chk("retired", 32'(instr_retired), 32'(ec));
    @(negedge clk);
  endtask

  task automatic do_reset();
    ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_ctrl", 32'(act_ctrl), 0);
    chk("rst_trap", 32'({trap, trap_cause}), 0);
    chk("rst_cnt", 32'(instr_retired), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_trap = 1'b0;
    exp_cause = 2'b00;
    exp_cnt = 0;
  endtask

  // expected cycle plan of one legal instruction
  task automatic run_instr(input int cls, input int wf,
                           input int wm, input logic z,
                           input logic [2:0] fn3,
                           input logic f7);
    op = op_of(cls);
    f3 = fn3;
    b5 = f7;
    zero = z;
    plan.delete();
    repeat (wf) add(0, 1'b0);
    add(0, 1'b1);
    add(1, rb());
    case (cls)
      0: begin
        add(2, rb());
        repeat (wm) add(3, 1'b0);
        add(3, 1'b1);
        add(4, rb());
      end
      1: begin
        add(2, rb());
        repeat (wm) add(5, 1'b0);
        add(5, 1'b1);
      end
      2: begin add(6, rb()); add(7, rb()); end
      3: begin add(8, rb()); add(7, rb()); end
      4: add(10, rb());
      default: begin add(9, rb()); add(7, rb()); end
    endcase
    foreach (plan[i]) cyc(plan[i].st, plan[i].rdy);
    exp_cnt++;
  endtask

  task automatic run_trap(input logic [6:0] o,
                          input logic [2:0] fn3,
                          input logic [1:0] c);
    op = o;
    f3 = fn3;
    cyc(0, 1'b1);
    cyc(1, rb());
    exp_trap = 1'b1;
    exp_cause = c;
    repeat (20) cyc(15, rb());
    do_reset();
  endtask

  initial begin
    logic [2:0] alu_f3 [4];
    int cls;
    logic [2:0] fn;
    alu_f3[0] = 3'b000;
    alu_f3[1] = 3'b010;
    alu_f3[2] = 3'b110;
    alu_f3[3] = 3'b111;

    @(negedge clk);
    do_reset();

    run_instr(2, 0, 0, 1'b0, 3'b000, 1'b0);
    run_instr(2, 0, 0, 1'b0, 3'b000, 1'b1);
    run_instr(0, 0, 3, 1'b0, 3'b010, 1'b0);
    run_instr(4, 0, 0, 1'b1, 3'b000, 1'b0);
    run_instr(4, 0, 0, 1'b0, 3'b000, 1'b0);
    run_instr(5, 0, 0, 1'b0, 3'b000, 1'b0);
    run_instr(3, 0, 0, 1'b0, 3'b000, 1'b1);
    run_instr(1, 0, 15, 1'b0, 3'b010, 1'b0);

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 5);
      fn = 3'($urandom_range(0, 7));
      if (cls == 2 || cls == 3)
        fn = alu_f3[$urandom_range(0, 3)];
      if (cls == 4) fn = 3'b000;
      run_instr(cls, $urandom_range(0, 15),
                $urandom_range(0, 15), rb(),
                fn, rb());
    end

    run_trap(7'b1111111, 3'b000, 2'b01);
    run_trap(7'b0110011, 3'b001, 2'b10);
    run_trap(7'b0010011, 3'b100, 2'b10);
    run_trap(7'b1100011, 3'b001, 2'b10);

    repeat (16) cyc(0, 1'b0);
    exp_trap = 1'b1;
    exp_cause = 2'b11;
    repeat (3) cyc(15, 1'b0);
    do_reset();

    run_instr(2, 15, 0, 1'b0, 3'b110, 1'b0);

    op = 7'b0000011;
    cyc(0, 1'b1);
    cyc(1, 1'b1);
    cyc(2, 1'b1);
    repeat (16) cyc(3, 1'b0);
    exp_trap = 1'b1;
    exp_cause = 2'b11;
    repeat (3) cyc(15, 1'b1);
    do_reset();

    run_instr(2, 0, 0, 1'b0, 3'b111, 1'b0);
    op = 7'b0100011;
    cyc(0, 1'b1);
    cyc(1, 1'b1);
    cyc(2, 1'b1);
    ready = 1'b0;
    #1;
    chk("mw_before", 32'({state_dbg, mem_write}),
        32'({4'd5, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mw_async", 32'({state_dbg, mem_write}), 0);
    chk("mw_cnt", 32'(instr_retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    run_instr(4, 0, 0, 1'b1, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
